fifo_ctrl_lvl: RTL and testbench

Parametrised FIFO pointer/status controller that drives an external dual-port register file. It provides the basic empty/full pointer management plus:
- occupancy count
- programmable almost-empty/almost-full thresholds
- qualified write/read enables
- sticky overflow/underflow error flags
- synchronous flush

Used in front of UART/FTDI/MCS I/O buffers where flow control needs watermark levels.

---
 rtl/fifo_ctrl_lvl.sv | 86 ++++++++
 tb/tb_fifo_ctrl_lvl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/status controller for an external dual-port register file.
// It keeps the occupancy count, watermark flags, qualified enables and sticky error flags.
module fifo_ctrl_lvl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic ovf_evt;
  logic udf_evt;

  // Status is decoded from the registered count only.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // A write into a full FIFO is allowed when a read frees the slot in the same cycle.
  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!flush) begin
      wr_en   = wr & (~full | rd);
      rd_en   = rd & ~empty;
      ovf_evt = wr & ~wr_en;
      udf_evt = rd & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      w_addr <= '0;
      r_addr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) w_addr <= w_addr + PTR_ONE;
      if (rd_en) r_addr <= r_addr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Errors survive flush; a new error in the clr_err cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Bench for fifo_ctrl_lvl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of FIFO occupancy.
module tb_fifo_ctrl_lvl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1, rd = 1'b0, wr = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic          wr_en, rd_en, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: queue of the slot addresses currently holding data.
  int m_q[$];
  int m_wp = 0, m_rp = 0;
  bit m_ovf = 1'b0, m_udf = 1'b0;

  fifo_ctrl_lvl #(.ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .rd_en(rd_en), .w_addr(w_addr), .r_addr(r_addr), .count(count),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_acc_w();
    return wr && !flush && (m_q.size() < DEPTH || rd);
  endfunction

  function automatic bit m_acc_r();
    return rd && !flush && m_q.size() > 0;
  endfunction

  task automatic model_update();
    bit aw, ar, oe, ue;
    aw = m_acc_w();
    ar = m_acc_r();
    oe = wr && !flush && !aw;
    ue = rd && !flush && m_q.size() == 0;
    if (reset) begin
      m_q.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (flush) begin
        m_q.delete(); m_wp = 0; m_rp = 0;
      end else begin
        if (ar) begin void'(m_q.pop_front()); m_rp = (m_rp + 1) % DEPTH; end
        if (aw) begin m_q.push_back(m_wp); m_wp = (m_wp + 1) % DEPTH; end
      end
      m_ovf = oe ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_udf = ue ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), m_q.size());
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("full", int'(full), int'(m_q.size() == DEPTH));
      chk("almost_empty", int'(almost_empty), int'(m_q.size() <= AEL));
      chk("almost_full", int'(almost_full), int'(m_q.size() >= AFL));
      chk("w_addr", int'(w_addr), m_wp);
      chk("r_addr", int'(r_addr), m_rp);
      if (m_q.size() > 0) chk("r_addr_oldest", int'(r_addr), m_q[0]);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
      chk("wr_en", int'(wr_en), int'(m_acc_w()));
      chk("rd_en", int'(rd_en), int'(m_acc_r()));
    end
  end

  task automatic step(input bit r, input bit w, input bit f, input bit c, input bit rs,
                      output bit we, output bit re);
    rd = r; wr = w; flush = f; clr_err = c; reset = rs;
    @(negedge clk);
    we = wr_en;
    re = rd_en;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    bit we, re;
    int wb;

    step(0, 0, 0, 0, 1, we, re);
    chk_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_flags", int'({overflow, underflow, full}), 0);

    // 1: fill, then one write too many
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, we, re);
      chk("s1_wr_en", int'(we), 1);
      chk("s1_count", int'(count), i + 1);
      chk("s1_ae", int'(almost_empty), int'(i == 0));
      chk("s1_af", int'(almost_full), int'(i >= 2));
    end
    chk("s1_full", int'(full), 1);
    chk("s1_wrap", int'(w_addr), 0);
    step(0, 1, 0, 0, 0, we, re);
    chk("s1_wr_rej", int'(we), 0);
    chk("s1_count4", int'(count), 4);
    chk("s1_ovf", int'(overflow), 1);

    // 2: drain, then one read too many, then clear errors
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, we, re);
      chk("s2_rd_en", int'(re), 1);
      chk("s2_raddr", int'(r_addr), (i + 1) % 4);
      chk("s2_count", int'(count), 3 - i);
    end
    chk("s2_empty", int'(empty), 1);
    step(1, 0, 0, 0, 0, we, re);
    chk("s2_rd_rej", int'(re), 0);
    chk("s2_udf", int'(underflow), 1);
    step(0, 0, 0, 1, 0, we, re);
    chk("s2_clr", int'({overflow, underflow}), 0);

    // 3: simultaneous rd&wr at count 2
    step(0, 1, 0, 0, 0, we, re);
    step(0, 1, 0, 0, 0, we, re);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 0, we, re);
      chk("s3_en", int'({we, re}), 3);
      chk("s3_count", int'(count), 2);
    end
    chk("s3_waddr", int'(w_addr), 0);
    chk("s3_raddr", int'(r_addr), 2);

    // 4: rd&wr on empty and on full
    step(0, 0, 1, 0, 0, we, re);
    step(1, 1, 0, 0, 0, we, re);
    chk("s4_e_en", int'({we, re}), 2);
    chk("s4_e_count", int'(count), 1);
    chk("s4_e_udf", int'(underflow), 1);
    step(0, 0, 0, 1, 0, we, re);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, we, re);
    chk("s4_full", int'(full), 1);
    step(1, 1, 0, 0, 0, we, re);
    chk("s4_f_en", int'({we, re}), 3);
    chk("s4_f_count", int'(count), 4);
    chk("s4_f_ovf", int'(overflow), 0);

    // 5: flush with wr while count 3 and overflow set
    step(0, 1, 0, 0, 0, we, re);
    step(1, 0, 0, 0, 0, we, re);
    chk("s5_pre", int'({count, overflow}), (3 << 1) | 1);
    step(0, 1, 1, 0, 0, we, re);
    chk("s5_wr_en", int'(we), 0);
    chk("s5_count", int'(count), 0);
    chk("s5_ptrs", int'({w_addr, r_addr}), 0);
    chk("s5_empty", int'(empty), 1);
    chk("s5_ovf", int'(overflow), 1);

    // 6: reset mid-stream, then clr_err racing a new overflow
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, we, re);
    step(0, 1, 0, 0, 1, we, re);
    chk("s6_count", int'(count), 0);
    chk("s6_ptrs", int'({w_addr, r_addr}), 0);
    chk("s6_stat", int'({empty, full, almost_empty, almost_full}), 4'b1010);
    chk("s6_err", int'({overflow, underflow}), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, we, re);
    step(0, 1, 0, 1, 0, we, re);
    chk("s6_set_wins", int'(overflow), 1);

    // Random traffic with a drifting write bias to visit full and empty often
    wb = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) wb = $urandom_range(10, 90);
      step($urandom_range(0, 99) >= wb, $urandom_range(0, 99) < wb,
           $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 299) == 0, we, re);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
